// File: rtl/down_timer.sv
// down_timer: loadable enable-gated down-counter with expiry pulse, auto-reload and expiry count
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             zero,
    output logic             done,
    output logic [WIDTH-1:0] periods
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out, r_reload, r_periods;
    logic [WIDTH-1:0] w_out_nxt, w_reload_nxt, w_periods_nxt;
    logic             r_done, w_done_nxt;
    logic             w_expire;
    assign w_expire = (r_state == RUN) && enable && (r_out == WIDTH'(1));
    // next state and datapath: load beats expiry, expiry reloads or stops, otherwise decrement
    always_comb begin
        w_state_nxt   = r_state;
        w_out_nxt     = r_out;
        w_reload_nxt  = r_reload;
        w_periods_nxt = r_periods;
        w_done_nxt    = 1'b0;
        if (load) begin
            w_out_nxt    = load_value;
            w_reload_nxt = load_value;
            w_state_nxt  = (load_value != '0) ? RUN : IDLE;
        end else if (w_expire) begin
            w_done_nxt    = 1'b1;
            w_periods_nxt = r_periods + WIDTH'(1);
            w_out_nxt     = auto_reload ? r_reload : '0;
            w_state_nxt   = auto_reload ? RUN : IDLE;
        end else if (r_state == RUN && enable && r_out != '0) begin
            w_out_nxt = r_out - WIDTH'(1);
        end
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_out     <= '0;
            r_reload  <= '0;
            r_periods <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out     <= w_out_nxt;
            r_reload  <= w_reload_nxt;
            r_periods <= w_periods_nxt;
            r_done    <= w_done_nxt;
        end
    end
    assign out     = r_out;
    assign busy    = (r_state == RUN);
    assign zero    = (r_out == '0);
    assign done    = r_done;
    assign periods = r_periods;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed test-plan sequences plus random stimulus against a reference model
module tb_down_timer;
    logic       clk = 1'b0;
    logic       reset, load, enable, auto_reload;
    logic [7:0] load_value;
    logic [7:0] out, periods;
    logic       busy, zero, done;
    int checks = 0;
    int errors = 0;
    int m_cnt, m_rel, m_per;
    bit m_run, m_done;

    down_timer #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .enable(enable), .auto_reload(auto_reload), .out(out), .busy(busy),
        .zero(zero), .done(done), .periods(periods)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // behavioural model: one clock edge of the timer's rules
    task automatic model_step();
        if (reset) begin
            m_cnt = 0; m_rel = 0; m_per = 0; m_run = 0; m_done = 0;
        end else if (load) begin
            m_cnt = load_value; m_rel = load_value; m_run = (load_value != 0); m_done = 0;
        end else if (m_run && enable && m_cnt == 1) begin
            m_done = 1;
            m_per  = (m_per + 1) % 256;
            if (auto_reload) m_cnt = m_rel;
            else begin m_cnt = 0; m_run = 0; end
        end else begin
            if (m_run && enable) m_cnt = m_cnt - 1;
            m_done = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("out", out, m_cnt);
        chk("busy", busy, m_run);
        chk("zero", zero, m_cnt == 0);
        chk("done", done, m_done);
        chk("periods", periods, m_per);
    endtask

    initial begin
        int e1[6] = '{5, 4, 3, 2, 1, 0};
        int e2[10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
        int e3[7] = '{4, 3, 3, 3, 2, 1, 0};
        bit en3[7] = '{1, 1, 0, 0, 1, 1, 1};
        int p0, dcnt;
        reset = 1; load = 0; enable = 0; auto_reload = 0; load_value = 0;
        @(negedge clk);
        cyc();
        chk("rst_out", out, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        reset = 0;
        // count from 5 without reload
        load = 1; load_value = 5; enable = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            load = 0;
            chk("t1_out", out, e1[i]);
            chk("t1_done", done, i == 5);
        end
        chk("t1_busy", busy, 0);
        chk("t1_per", periods, 1);
        // auto-reload of 3
        load = 1; load_value = 3; auto_reload = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            load = 0;
            chk("t2_out", out, e2[i]);
            chk("t2_done", done, i == 3 || i == 6 || i == 9);
        end
        // enable toggling, holds do not count
        load = 1; load_value = 4; auto_reload = 0;
        dcnt = 0;
        for (int i = 0; i < 7; i++) begin
            enable = en3[i];
            cyc();
            load = 0;
            chk("t3_out", out, e3[i]);
            dcnt += done;
        end
        chk("t3_done_once", dcnt, 1);
        // load zero stays idle, enable ignored
        p0 = periods;
        load = 1; load_value = 0; enable = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            load = 0;
            chk("t4_out", out, 0);
            chk("t4_done", done, 0);
        end
        chk("t4_per", periods, p0);
        // load colliding with expiry
        load = 1; load_value = 2; auto_reload = 1;
        cyc(); load = 0;
        cyc();
        chk("t5_pre", out, 1);
        p0 = periods;
        load = 1; load_value = 7;
        cyc(); load = 0;
        chk("t5_out", out, 7);
        chk("t5_done", done, 0);
        chk("t5_per", periods, p0);
        cyc();
        chk("t5_resume", out, 6);
        // reset mid-count, then wrap periods with reload of 1
        load = 1; load_value = 200; auto_reload = 0;
        for (int i = 0; i < 101; i++) begin cyc(); load = 0; end
        chk("t6_mid", out, 100);
        reset = 1;
        cyc();
        reset = 0;
        chk("t6_out", out, 0);
        chk("t6_per", periods, 0);
        load = 1; load_value = 1; auto_reload = 1;
        cyc(); load = 0;
        for (int i = 0; i < 256; i++) cyc();
        chk("t6_wrap", periods, 0);
        chk("t6_done_each", done, 1);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            load        = ($urandom_range(0, 7) == 0);
            load_value  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            enable      = ($urandom_range(0, 3) != 0);
            auto_reload = 1'($urandom);
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
